// File: rtl/pdecoder2to4_seq_if.sv
// Handshake/bus bundle for pdecoder2to4_seq.
//   master : upstream side, drives in_valid/in and observes everything else.
//   slave  : decoder side, drives in_ready, out, out_valid, busy, fill.
// IN_W sets the code width; OUT_W (one-hot width) is derived as 2**IN_W.
interface pdecoder2to4_seq_if #(
  parameter int IN_W = 2
);
  localparam int OUT_W = 2 ** IN_W;

  logic              in_valid;
  logic [IN_W-1:0]   in;
  logic              in_ready;
  logic [OUT_W-1:0]  out;
  logic              out_valid;
  logic              busy;
  logic [1:0]        fill;

  modport master (
    output in_valid, in,
    input  in_ready, out, out_valid, busy, fill
  );

  modport slave (
    input  in_valid, in,
    output in_ready, out, out_valid, busy, fill
  );
endinterface

// File: rtl/pdecoder2to4_seq.sv
// Sequential 2-to-4 decoder with a 2-entry input FIFO.
// Codes arrive over a valid/ready handshake, are buffered, and each is
// replayed as a registered one-hot word held on out for HOLD_CYCLES clocks.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave modport of pdecoder2to4_seq_if
//           in_valid/in  -> code offered
//           in_ready     <- FIFO not full (depends on fill only)
//           out          <- registered one-hot word or zero
//           out_valid    <- out holds a decoded word
//           busy         <- HOLD state or FIFO non-empty
//           fill         <- FIFO occupancy 0..2
module pdecoder2to4_seq #(
  parameter int IN_W        = 2,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pdecoder2to4_seq_if.slave       bus
);
  localparam int         OUT_W = 2 ** IN_W;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [IN_W-1:0]   mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fill_q, fill_d;
  logic              push, pop;

  // in_ready looks at fill only, so a full FIFO never takes a push even
  // on the cycle it pops.
  assign push = bus.in_valid && (fill_q != FULL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fill_q != 2'd0) begin
          pop         = 1'b1;
          out_d       = OUT_W'(1) << mem_q[rd_ptr_q];
          out_valid_d = 1'b1;
          cnt_d       = RELOAD;
          state_d     = HOLD;
        end else begin
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (fill_q != 2'd0) begin
          // Back-to-back reload: next word replaces the current one on
          // the same edge, so out never drops to zero between words.
          pop         = 1'b1;
          out_d       = OUT_W'(1) << mem_q[rd_ptr_q];
          out_valid_d = 1'b1;
          cnt_d       = RELOAD;
        end else begin
          out_d       = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;

    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + 2'd1;
    end else if (pop && !push) begin
      fill_d = fill_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.in;
      end
    end
  end

  assign bus.in_ready  = (fill_q != FULL);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == HOLD) || (fill_q != 2'd0);
  assign bus.fill      = fill_q;
endmodule

// File: tb/tb_pdecoder2to4_seq.sv
module tb_pdecoder2to4_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0 holds each word 3 cycles, dut1 holds each word 1 cycle
  pdecoder2to4_seq_if #(.IN_W(2)) if0 ();
  pdecoder2to4_seq_if #(.IN_W(2)) if1 ();

  pdecoder2to4_seq #(.IN_W(2), .HOLD_CYCLES(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  pdecoder2to4_seq #(.IN_W(2), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic       iv [2];
  logic [1:0] ic [2];
  logic [3:0] o_out [2];
  logic       o_val [2];
  logic       o_rdy [2];
  logic       o_busy [2];
  logic [1:0] o_fill [2];
  assign iv[0] = if0.in_valid;  assign iv[1] = if1.in_valid;
  assign ic[0] = if0.in;        assign ic[1] = if1.in;
  assign o_out[0] = if0.out;    assign o_out[1] = if1.out;
  assign o_val[0] = if0.out_valid; assign o_val[1] = if1.out_valid;
  assign o_rdy[0] = if0.in_ready;  assign o_rdy[1] = if1.in_ready;
  assign o_busy[0] = if0.busy;  assign o_busy[1] = if1.busy;
  assign o_fill[0] = if0.fill;  assign o_fill[1] = if1.fill;

  // Reference model: a code queue (max 2) plus the word currently shown
  // and how many more cycles it remains on the output.
  logic [1:0] mq [2][2];
  int         mcnt [2];
  int         rem [2];
  logic [3:0] cur [2];
  int         acc_cnt [2];
  bit         mvalid = 1'b0;
  logic [3:0] sb0 [$];
  logic [3:0] sb1 [$];

  int  n_chk = 0;
  int  n_fail = 0;
  bit  to_err = 1'b0;
  bit  end_chk = 1'b0;
  bit  end_done = 1'b0;

  function automatic int hold_of(int d);
    return (d == 0) ? 3 : 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mcnt[d] = 0; rem[d] = 0; cur[d] = 4'b0;
      end
      sb0.delete(); sb1.delete();
      mvalid = 1'b1;
    end else if (mvalid) begin
      for (int d = 0; d < 2; d++) begin
        bit acc;
        logic [3:0] w;
        acc = iv[d] && (mcnt[d] < 2);
        if (rem[d] > 1) begin
          rem[d]--;
        end else if (mcnt[d] > 0) begin
          cur[d] = 4'b0001 << mq[d][0];
          mq[d][0] = mq[d][1];
          mcnt[d]--;
          rem[d] = hold_of(d);
        end else begin
          cur[d] = 4'b0; rem[d] = 0;
        end
        if (acc) begin
          mq[d][mcnt[d]] = ic[d];
          mcnt[d]++;
          acc_cnt[d]++;
          w = 4'b0001 << ic[d];
          for (int k = 0; k < hold_of(d); k++) begin
            if (d == 0) sb0.push_back(w); else sb1.push_back(w);
          end
        end
      end
    end
  end

  task automatic chk(string nm, int d, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
    end
  endtask

  // Monitor: cycle-level checks plus scoreboard pop whenever out_valid.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] w;
        chk("out", d, int'(o_out[d]), int'(cur[d]));
        chk("out_valid", d, int'(o_val[d]), int'(cur[d] != 4'b0));
        chk("fill", d, int'(o_fill[d]), mcnt[d]);
        chk("in_ready", d, int'(o_rdy[d]), int'(mcnt[d] < 2));
        chk("busy", d, int'(o_busy[d]), int'(rem[d] > 0 || mcnt[d] > 0));
        if (o_val[d] === 1'b1) begin
          if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            n_chk++; n_fail++;
            $display("FAIL dut%0d scoreboard: out %0h with no expected word", d, o_out[d]);
          end else begin
            w = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("sb_word", d, int'(o_out[d]), int'(w));
          end
        end
      end
      if (end_chk && !end_done) begin
        chk("sb_left", 0, sb0.size(), 0);
        chk("sb_left", 1, sb1.size(), 0);
        chk("timeout", 0, int'(to_err), 0);
        end_done = 1'b1;
      end
    end
  end

  task automatic set_in(int d, logic v, logic [1:0] c);
    if (d == 0) begin if0.in_valid = v; if0.in = c; end
    else begin if1.in_valid = v; if1.in = c; end
  endtask

  // Offer a code and keep valid high until the model sees it accepted.
  task automatic send(int d, logic [1:0] c);
    int start;
    start = acc_cnt[d];
    set_in(d, 1'b1, c);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_cnt[d] != start) return;
    end
    to_err = 1'b1;
  endtask

  task automatic wait_idle(int d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mcnt[d] == 0 && rem[d] == 0) return;
    end
    to_err = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_in(0, 1'b1, 2'b11);
    set_in(1, 1'b1, 2'b11);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 1'b0, 2'b00);
    set_in(1, 1'b0, 2'b00);
    repeat (2) @(negedge clk);

    // single code
    send(0, 2'b10); set_in(0, 1'b0, 2'b00); wait_idle(0);
    // back-to-back
    send(0, 2'b00); send(0, 2'b01); send(0, 2'b11);
    set_in(0, 1'b0, 2'b00); wait_idle(0);
    // fill to 2, then offer 01 while full
    send(0, 2'b00); send(0, 2'b10); send(0, 2'b11); send(0, 2'b01);
    set_in(0, 1'b0, 2'b00); wait_idle(0);
    // reset while holding with one code queued
    send(0, 2'b10); send(0, 2'b01); set_in(0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // HOLD_CYCLES=1 sweep
    for (int c = 0; c < 4; c++) send(1, 2'(c));
    set_in(1, 1'b0, 2'b00); wait_idle(1);

    // randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_in(d, 1'b0, 2'b00);
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        send(d, 2'($urandom_range(0, 3)));
      end
      set_in(d, 1'b0, 2'b00);
      wait_idle(d);
    end

    repeat (2) @(negedge clk);
    end_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pdecoder2to4_seq.md
Name: pdecoder2to4_seq

Overview:
Sequential companion to the 4-to-2 priority encoder: the decode side of the same index interface. It accepts 2-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO. Each code is replayed as a registered one-hot 4-bit output, held for HOLD_CYCLES clocks. It sits downstream of the encoder and drives one-hot select/enable lines.

Parameters:
IN_W, 2, code width; OUT_W = 2**IN_W, derived and not overridable.
HOLD_CYCLES, 3, cycles each one-hot word is held on out (legal 1..255).
DEPTH, 2, input FIFO entries (fixed at 2; pointers are 1 bit).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  code on in is offered.
in  input  IN_W  code to decode.
in_ready  output  1  FIFO can accept; equals !full.
out  output  OUT_W  registered one-hot word (1 << code) or all zero.
out_valid  output  1  out currently holds a decoded word.
busy  output  1  FSM in HOLD or FIFO non-empty.
fill  output  2  FIFO occupancy, 0..2.

Behaviour:
- Reset is synchronous, sampled on rising clk with rst_n=0. Reset values: out=0, out_valid=0, FIFO empty (fill=0), in_ready=1, state=IDLE, cnt=0, busy=0. Reset mid-HOLD clears everything on that edge; pending FIFO entries are discarded.
- Accept: a push happens on an edge with in_valid && in_ready. The code is written at the write pointer and fill increments.
- in_ready is combinational from fill only (fill<2). It does not depend on a same-cycle pop, so there is no push into a full FIFO even while popping.
- Simultaneous push and pop: fill is unchanged and both pointers advance.
- FSM states: IDLE, HOLD.
- IDLE: if fill>0, pop the head entry. Register out = 1<<code, out_valid=1, cnt=HOLD_CYCLES-1, go to HOLD. Otherwise out=0 and out_valid=0.
- HOLD, cnt>0: out is held and cnt decrements by 1.
- HOLD, cnt==0 with fill>0: pop the next entry and load it into out in the same edge (back-to-back, no zero gap). cnt reloads to HOLD_CYCLES-1.
- HOLD, cnt==0 with fill==0: out=0, out_valid=0, go to IDLE.
- Latency: a code accepted at edge N into an empty FIFO with the FSM in IDLE appears on out after edge N+1. It stays for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1: every word is held one cycle. Consecutive queued codes appear on consecutive cycles.
- out is always one-hot or zero; it is never multi-hot. out_valid == (out != 0).
- Codes are passed verbatim; all 2**IN_W values are legal, so there is no error case.
- Pointers wrap modulo DEPTH. fill is a saturating-free 0..2 counter. An underflow is impossible because pop is gated by fill>0.
- busy = (state==HOLD) || (fill!=0).

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with in_valid=1, in=2'b11 -> out=0, out_valid=0, fill=0, in_ready=1, no push.
- Single code, HOLD_CYCLES=3: push in=2'b10 at edge 5 -> out=4'b0100 for edges 6..8 (3 cycles), then out=0 and busy=0 after edge 9.
- Back-to-back: push 2'b00, 2'b01, 2'b11 on consecutive edges -> out=0001 x3, 0010 x3, 1000 x3 with no zero gap. in_ready deasserts only if fill reaches 2. All three are accepted when offered with valid held.
- Full FIFO: while holding the first word, push 2 more codes so fill=2 and in_ready=0. Then offer in=2'b01 -> not accepted. It is accepted on the edge after the pop makes fill=1.
- Reset mid-HOLD: out=4'b0100 with cnt=1 and fill=1, then assert rst_n=0 for 1 cycle -> next cycle out=0, fill=0, state IDLE. The queued code never appears.
- HOLD_CYCLES=1 sweep: push all four codes 0..3 -> out sequence 0001, 0010, 0100, 1000 on 4 consecutive cycles, then 0.
